mem_stage: RTL and testbench
============================

# mem_stage

Memory-access and PC-update stage of the Y86 SEQ datapath; it consumes the execute results (`valE`, `cnd`) together with the decode/fetch values. It drives a single-port data-memory request/acknowledge interface for the six memory-touching instructions. It returns `valM` and the next PC, and flags out-of-range or timed-out accesses. A multi-cycle FSM replaces the combinational memory of the reference SEQ core, so execute's results are registered and held here until the access completes.

## Interface
- `MEM_BYTES`, 1024: size of data memory in bytes; valid accesses satisfy `addr + 8 <= MEM_BYTES`
- `TIMEOUT`, 16: maximum edges in ACCESS without `mem_ack` before an error is declared
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  execute results valid this cycle; sampled only in IDLE
- `icode`  in  4  instruction code
- `cnd`  in  1  condition result from execute
- `valE`  in  64  ALU/address result from execute
- `valA`  in  64  register A value
- `valC`  in  64  constant word
- `valP`  in  64  sequential next PC
- `mem_req`  out  1  memory request, held until ack or timeout
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`
- `mem_addr`  out  64  byte address; valid while `mem_req`
- `mem_wdata`  out  64  write data; valid while `mem_req && mem_we`
- `mem_rdata`  in  64  read data, valid when `mem_ack`
- `mem_ack`  in  1  access complete
- `busy`  out  1  high in ACCESS and DONE
- `done`  out  1  one-cycle pulse; `valM`, `new_pc`, `dmem_error` valid
- `valM`  out  64  read data
- `new_pc`  out  64  next PC
- `dmem_error`  out  1  access failed (range or timeout)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE + `start`=1: latch all inputs, clear `valM` and `dmem_error`. Then decode:
  - 4 rmmovq: write, addr `valE`, data `valA`
  - 5 mrmovq: read, addr `valE`
  - 8 call: write, addr `valE`, data `valP`
  - 9 ret: read, addr `valA`
  - A pushq: write, addr `valE`, data `valA`
  - B popq: read, addr `valA`
  - all others: no access; go to DONE.
- Range check is on the latched address using 65-bit arithmetic, so `addr + 8` never wraps.
  - Fail: set `dmem_error`, go to DONE, never assert `mem_req`.
  - Pass: go to ACCESS.
- ACCESS:
  - `mem_req`=1; `mem_we`/`mem_addr`/`mem_wdata` are stable from latched values.
  - Edge with `mem_ack`=1: on a read, `valM` <= `mem_rdata`; go to DONE.
  - Each edge without ack increments the wait counter. When the counter reaches `TIMEOUT`: set `dmem_error`, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `new_pc` is registered on entry to DONE:
  - call: `valC`
  - ret: `valM`, or `valP` if `dmem_error`
  - 7 jxx: `cnd ? valC : valP`
  - else: `valP`
- `start` while `busy` is ignored; there is no queueing.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset, at any edge with `rst_n`=0, including mid-access: state IDLE and wait counter 0. Every output is 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `valM`, `new_pc`, `dmem_error`. Any outstanding request is dropped without waiting for ack.
- No-access instruction or range error: `start` sampled at edge E0; `done` high in the cycle after E0.
- Memory access: `start` at E0; `mem_req` high after E0; ack sampled at E(k) with k>=1; `mem_req` low and `done` high after E(k). Minimum `start`-to-`done` is 2 edges.
- Timeout: `mem_req` stays high for exactly `TIMEOUT` cycles, then drops together with `done` rising.
- `mem_ack` on the same edge that the timeout count is reached: the ack wins, and `dmem_error` stays 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `valM`, `new_pc` and `dmem_error` hold their values after `done` until the next accepted `start`.

## Test plan
- Reset mid-ACCESS: mrmovq started, `rst_n`=0 for one edge before ack -> next cycle `mem_req`=0, `busy`=0, `valM`=0, `new_pc`=0; a later ack is ignored.
- mrmovq, `valE`=0x40, ack after 3 cycles with `mem_rdata`=0x1122334455667788. Required:
  - `mem_req` high exactly 3 cycles, `mem_we`=0, `mem_addr`=0x40
  - `done` pulse with `valM`=0x1122334455667788 and `new_pc`=`valP`
- call, `valE`=0x3F8, `valP`=0x1D, `valC`=0x100, immediate ack. Required:
  - write with `mem_addr`=0x3F8, `mem_wdata`=0x1D
  - `new_pc`=0x100; latency 2 edges
- ret, `valA`=0x3F8, ack with rdata 0x1D -> read at 0x3F8, `new_pc`=0x1D.
- jxx, `cnd`=0, `valC`=0x80, `valP`=0x2A -> no `mem_req`, `done` 1 cycle after start, `new_pc`=0x2A; repeat with `cnd`=1 -> `new_pc`=0x80.
- Error and busy cases:
  - pushq, `valE`=0x3FC, `MEM_BYTES`=1024 -> `dmem_error`=1, no `mem_req`.
  - rmmovq with no ack -> `mem_req` high 16 cycles, `dmem_error`=1.
  - `start` pulsed during ACCESS -> ignored.

Source files
------------

// File: rtl/mem_stage.sv
// Y86 SEQ memory-access and PC-update stage with a request/acknowledge data-memory port.
// Execute results are latched on start and held until the access completes.
module mem_stage #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic [63:0] new_pc,
    output logic        dmem_error
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned XLEN  = 64;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
    logic [3:0]        icode_q, icode_d;
    logic [XLEN-1:0]   valc_q, valc_d, valp_q, valp_d;
    logic              mem_req_d, mem_we_d, busy_d, done_d, dmem_error_d;
    logic [XLEN-1:0]   mem_addr_d, mem_wdata_d, valM_d, new_pc_d;
    logic              dec_acc, dec_we, in_range;
    logic [XLEN-1:0]   dec_addr, dec_wdata;

    function automatic logic [XLEN-1:0] pick_pc(input logic [3:0] ic, input logic c,
                                                 input logic [XLEN-1:0] k, input logic [XLEN-1:0] p,
                                                 input logic [XLEN-1:0] m, input logic err);
        case (ic)
            I_CALL:  pick_pc = k;
            I_RET:   pick_pc = err ? p : m;
            I_JXX:   pick_pc = c ? k : p;
            default: pick_pc = p;
        endcase
    endfunction

    // Memory access implied by the incoming instruction; 65-bit bound check cannot wrap
    always_comb begin
        dec_acc   = 1'b1;
        dec_we    = 1'b0;
        dec_addr  = valE;
        dec_wdata = '0;
        case (icode)
            I_RMMOVQ, I_PUSHQ: begin
                dec_we    = 1'b1;
                dec_wdata = valA;
            end
            I_MRMOVQ: dec_we = 1'b0;
            I_CALL: begin
                dec_we    = 1'b1;
                dec_wdata = valP;
            end
            I_RET, I_POPQ: dec_addr = valA;
            default: dec_acc = 1'b0;
        endcase
        in_range = ({1'b0, dec_addr} + 65'd8) <= 65'(MEM_BYTES);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        wait_cnt_d   = wait_cnt;
        icode_d      = icode_q;
        valc_d       = valc_q;
        valp_d       = valp_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        busy_d       = busy;
        done_d       = 1'b0;
        valM_d       = valM;
        new_pc_d     = new_pc;
        dmem_error_d = dmem_error;

        case (state)
            S_IDLE: begin
                if (start) begin
                    icode_d      = icode;
                    valc_d       = valC;
                    valp_d       = valP;
                    valM_d       = '0;
                    dmem_error_d = 1'b0;
                    busy_d       = 1'b1;
                    wait_cnt_d   = '0;
                    if (!dec_acc) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        new_pc_d = pick_pc(icode, cnd, valC, valP, '0, 1'b0);
                    end else if (!in_range) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        dmem_error_d = 1'b1;
                        new_pc_d     = pick_pc(icode, cnd, valC, valP, '0, 1'b1);
                    end else begin
                        state_d     = S_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dec_we;
                        mem_addr_d  = dec_addr;
                        mem_wdata_d = dec_wdata;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack || wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    wait_cnt_d  = '0;
                    if (mem_ack) begin
                        if (!mem_we) begin
                            valM_d = mem_rdata;
                        end
                        new_pc_d = pick_pc(icode_q, 1'b0, valc_q, valp_q,
                                           mem_we ? valM : mem_rdata, 1'b0);
                    end else begin
                        dmem_error_d = 1'b1;
                        new_pc_d     = pick_pc(icode_q, 1'b0, valc_q, valp_q, valM, 1'b1);
                    end
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            icode_q    <= '0;
            valc_q     <= '0;
            valp_q     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valM       <= '0;
            new_pc     <= '0;
            dmem_error <= 1'b0;
        end else begin
            state      <= state_d;
            wait_cnt   <= wait_cnt_d;
            icode_q    <= icode_d;
            valc_q     <= valc_d;
            valp_q     <= valp_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            busy       <= busy_d;
            done       <= done_d;
            valM       <= valM_d;
            new_pc     <= new_pc_d;
            dmem_error <= dmem_error_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// compared against a behavioural model of the stage.
module tb_mem_stage;
    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned TIMEOUT   = 16;

    logic        clk, rst_n, start, cnd, mem_req, mem_we, mem_ack, busy, done, dmem_error;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valC, valP, mem_addr, mem_wdata, mem_rdata, valM, new_pc;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int          req_cycles;
        int          latency;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        stable;
        logic [63:0] valM;
        logic [63:0] new_pc;
        logic        err;
        logic        busy_first;
        logic        done_after;
        logic        held;
        logic        hung;
    } obs_t;

    typedef struct {
        int          req_cycles;
        int          latency;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] valM;
        logic [63:0] new_pc;
        logic        err;
    } exp_t;

    mem_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .cnd(cnd),
        .valE(valE), .valA(valA), .valC(valC), .valP(valP),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
        .valM(valM), .new_pc(new_pc), .dmem_error(dmem_error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural model: what one transaction should look like from the outside.
    function automatic exp_t model(input logic [3:0] ic, input logic c, input logic [63:0] e,
                                   input logic [63:0] a, input logic [63:0] k, input logic [63:0] p,
                                   input int ack_after, input logic [63:0] rd);
        exp_t x;
        bit   acc = 1;
        x = '{default: '0};
        case (ic)
            4'h4, 4'hA: begin x.we = 1; x.addr = e; x.wdata = a; end
            4'h5:       x.addr = e;
            4'h8:       begin x.we = 1; x.addr = e; x.wdata = p; end
            4'h9, 4'hB: x.addr = a;
            default:    acc = 0;
        endcase
        if (!acc) begin
            x.latency = 1;
        end else if (x.addr > 64'(MEM_BYTES) - 64'd8) begin
            x.err = 1; x.latency = 1;
        end else if (ack_after < 1 || ack_after > int'(TIMEOUT)) begin
            x.req_cycles = int'(TIMEOUT); x.latency = int'(TIMEOUT) + 1; x.err = 1;
        end else begin
            x.req_cycles = ack_after; x.latency = ack_after + 1;
            if (!x.we) x.valM = rd;
        end
        case (ic)
            4'h8:    x.new_pc = k;
            4'h9:    x.new_pc = x.err ? p : x.valM;
            4'h7:    x.new_pc = c ? k : p;
            default: x.new_pc = p;
        endcase
        return x;
    endfunction

    // Drives one transaction; ack_after = n acks in the n-th request cycle, 0 = never.
    task automatic run_txn(input logic [3:0] ic, input logic c, input logic [63:0] e,
                           input logic [63:0] a, input logic [63:0] k, input logic [63:0] p,
                           input int ack_after, input logic [63:0] rd, input bit poke,
                           output obs_t o);
        o = '{default: '0};
        o.stable = 1;
        icode = ic; cnd = c; valE = e; valA = a; valC = k; valP = p; start = 1;
        tick;
        start = 0;
        o.latency = 1;
        o.busy_first = busy;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            if (mem_req) begin
                if (o.req_cycles == 0) begin
                    o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
                end else if (mem_we !== o.we || mem_addr !== o.addr || mem_wdata !== o.wdata) begin
                    o.stable = 0;
                end
                o.req_cycles++;
                if (o.req_cycles == ack_after) begin
                    mem_ack = 1; mem_rdata = rd;
                end
                if (poke && o.req_cycles == 1) begin
                    start = 1; icode = 4'h7; cnd = 1; valC = ~k; valP = ~p; valE = ~e; valA = ~a;
                end
            end
            tick;
            mem_ack = 0; start = 0;
            mem_rdata = {$urandom, $urandom};
            o.latency++;
        end
        o.hung   = !done;
        o.valM   = valM;
        o.new_pc = new_pc;
        o.err    = dmem_error;
        tick;
        o.done_after = done;
        o.held = (valM === o.valM) && (new_pc === o.new_pc) && (dmem_error === o.err) && !busy && !mem_req;
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick; tick;
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, busy, done, valM, new_pc, dmem_error} !== '0)
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h busy=%b done=%b valM=%h pc=%h err=%b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, busy, done, valM, new_pc, dmem_error);
        else n_pass++;
        rst_n = 1;
        tick;
    endtask

    task automatic test_mrmovq;
        obs_t o;
        run_txn(4'h5, 0, 64'h40, 64'h9, 64'h5, 64'h77, 3, 64'h1122334455667788, 0, o);
        n_total++; if (o.req_cycles !== 3) $display("FAIL mrmovq_req_cycles: got %0d want 3", o.req_cycles); else n_pass++;
        n_total++; if (o.we !== 1'b0 || o.addr !== 64'h40) $display("FAIL mrmovq_req: got we=%b addr=%h want we=0 addr=40", o.we, o.addr); else n_pass++;
        n_total++; if (o.valM !== 64'h1122334455667788) $display("FAIL mrmovq_valM: got %h want 1122334455667788", o.valM); else n_pass++;
        n_total++; if (o.new_pc !== 64'h77 || o.err !== 1'b0) $display("FAIL mrmovq_pc: got pc=%h err=%b want pc=77 err=0", o.new_pc, o.err); else n_pass++;
        n_total++; if (o.latency !== 4 || o.busy_first !== 1'b1) $display("FAIL mrmovq_latency: got %0d busy=%b want 4 busy=1", o.latency, o.busy_first); else n_pass++;
        n_total++; if (o.done_after !== 1'b0 || !o.held) $display("FAIL mrmovq_done_pulse: got done=%b held=%b want 0/1", o.done_after, o.held); else n_pass++;
    endtask

    task automatic test_reset_mid_access;
        icode = 4'h5; valE = 64'h80; valA = 0; valC = 0; valP = 64'h99; start = 1;
        tick;
        start = 0;
        tick;
        n_total++; if (mem_req !== 1'b1) $display("FAIL rstmid_req_before: got %b want 1", mem_req); else n_pass++;
        rst_n = 0;
        tick;
        n_total++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || valM !== '0 || new_pc !== '0)
            $display("FAIL rstmid_cleared: got req=%b busy=%b valM=%h pc=%h want 0", mem_req, busy, valM, new_pc);
        else n_pass++;
        rst_n = 1; mem_ack = 1; mem_rdata = 64'hDEAD;
        tick; tick;
        mem_ack = 0;
        n_total++;
        if (done !== 1'b0 || valM !== '0 || mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstmid_late_ack: got done=%b valM=%h req=%b busy=%b want 0", done, valM, mem_req, busy);
        else n_pass++;
    endtask

    task automatic test_call;
        obs_t o;
        run_txn(4'h8, 0, 64'h3F8, 64'h5, 64'h100, 64'h1D, 1, 64'h0, 0, o);
        n_total++; if (o.we !== 1'b1 || o.addr !== 64'h3F8 || o.wdata !== 64'h1D) $display("FAIL call_req: got we=%b addr=%h wd=%h want 1/3f8/1d", o.we, o.addr, o.wdata); else n_pass++;
        n_total++; if (o.new_pc !== 64'h100 || o.err !== 1'b0) $display("FAIL call_pc: got pc=%h err=%b want 100/0", o.new_pc, o.err); else n_pass++;
        n_total++; if (o.latency !== 2 || o.req_cycles !== 1) $display("FAIL call_latency: got %0d req=%0d want 2/1", o.latency, o.req_cycles); else n_pass++;
    endtask

    task automatic test_ret;
        obs_t o;
        run_txn(4'h9, 0, 64'h500, 64'h3F8, 64'h100, 64'h44, 2, 64'h1D, 0, o);
        n_total++; if (o.we !== 1'b0 || o.addr !== 64'h3F8) $display("FAIL ret_req: got we=%b addr=%h want 0/3f8", o.we, o.addr); else n_pass++;
        n_total++; if (o.new_pc !== 64'h1D || o.valM !== 64'h1D || o.err !== 1'b0) $display("FAIL ret_pc: got pc=%h valM=%h err=%b want 1d/1d/0", o.new_pc, o.valM, o.err); else n_pass++;
    endtask

    task automatic test_jxx;
        obs_t o;
        for (int c = 0; c < 2; c++) begin
            run_txn(4'h7, 1'(c), 64'h10, 64'h20, 64'h80, 64'h2A, 1, 64'h0, 0, o);
            n_total++;
            if (o.req_cycles !== 0 || o.latency !== 1 || o.new_pc !== (c == 1 ? 64'h80 : 64'h2A) || o.valM !== '0)
                $display("FAIL jxx_cnd%0d: got req=%0d lat=%0d pc=%h valM=%h", c, o.req_cycles, o.latency, o.new_pc, o.valM);
            else n_pass++;
        end
    endtask

    task automatic test_range_error;
        obs_t o;
        run_txn(4'hA, 0, 64'h3FC, 64'h1, 64'h2, 64'h33, 1, 64'h0, 0, o);
        n_total++; if (o.err !== 1'b1 || o.req_cycles !== 0 || o.latency !== 1 || o.new_pc !== 64'h33) $display("FAIL range_pushq: got err=%b req=%0d lat=%0d pc=%h want 1/0/1/33", o.err, o.req_cycles, o.latency, o.new_pc); else n_pass++;
        run_txn(4'h4, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 64'h2, 64'h34, 1, 64'h0, 0, o);
        n_total++; if (o.err !== 1'b1 || o.req_cycles !== 0) $display("FAIL range_wrap: got err=%b req=%0d want 1/0", o.err, o.req_cycles); else n_pass++;
        run_txn(4'h9, 0, 64'h0, 64'h3F9, 64'h2, 64'h35, 1, 64'h0, 0, o);
        n_total++; if (o.err !== 1'b1 || o.new_pc !== 64'h35) $display("FAIL range_ret: got err=%b pc=%h want 1/35", o.err, o.new_pc); else n_pass++;
    endtask

    task automatic test_timeout;
        obs_t o;
        run_txn(4'h4, 0, 64'h10, 64'hAB, 64'h2, 64'h36, 0, 64'h0, 0, o);
        n_total++; if (o.req_cycles !== 16 || o.err !== 1'b1 || o.latency !== 17) $display("FAIL timeout_rmmovq: got req=%0d err=%b lat=%0d want 16/1/17", o.req_cycles, o.err, o.latency); else n_pass++;
        n_total++; if (o.new_pc !== 64'h36 || !o.held || o.hung) $display("FAIL timeout_hold: got pc=%h held=%b hung=%b want 36/1/0", o.new_pc, o.held, o.hung); else n_pass++;
        run_txn(4'h5, 0, 64'h18, 64'h0, 64'h2, 64'h37, 16, 64'hCAFE, 0, o);
        n_total++; if (o.err !== 1'b0 || o.valM !== 64'hCAFE || o.req_cycles !== 16) $display("FAIL timeout_ack_wins: got err=%b valM=%h req=%0d want 0/cafe/16", o.err, o.valM, o.req_cycles); else n_pass++;
    endtask

    task automatic test_start_ignored;
        obs_t o;
        run_txn(4'h4, 0, 64'h20, 64'hABCD, 64'h2, 64'h38, 3, 64'h0, 1, o);
        n_total++; if (!o.stable || o.wdata !== 64'hABCD || o.addr !== 64'h20) $display("FAIL ignore_req_stable: got stable=%b addr=%h wd=%h want 1/20/abcd", o.stable, o.addr, o.wdata); else n_pass++;
        n_total++; if (o.new_pc !== 64'h38 || o.req_cycles !== 3) $display("FAIL ignore_pc: got pc=%h req=%0d want 38/3", o.new_pc, o.req_cycles); else n_pass++;
        n_total++; if (o.done_after !== 1'b0 || !o.held) $display("FAIL ignore_no_second: got done=%b held=%b want 0/1", o.done_after, o.held); else n_pass++;
    endtask

    task automatic test_random;
        obs_t        o;
        exp_t        x;
        logic [3:0]  ic;
        logic [63:0] e, a, k, p, rd;
        logic        c;
        int          ack_after;
        for (int t = 0; t < 40; t++) begin
            ic = 4'($urandom_range(0, 11));
            c  = 1'($urandom);
            k  = {$urandom, $urandom};
            p  = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       e = 64'($urandom_range(0, 1016));
                1:       e = 64'($urandom_range(1017, 1100));
                2:       e = {$urandom, $urandom};
                default: e = 64'd1016;
            endcase
            a = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 1030)) : e;
            ack_after = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 5);
            x = model(ic, c, e, a, k, p, ack_after, rd);
            run_txn(ic, c, e, a, k, p, ack_after, rd, 0, o);
            n_total++;
            if (o.hung || o.req_cycles !== x.req_cycles || o.latency !== x.latency)
                $display("FAIL rand%0d_timing ic=%h: got req=%0d lat=%0d hung=%b want req=%0d lat=%0d", t, ic, o.req_cycles, o.latency, o.hung, x.req_cycles, x.latency);
            else n_pass++;
            n_total++;
            if (o.valM !== x.valM || o.new_pc !== x.new_pc || o.err !== x.err)
                $display("FAIL rand%0d_result ic=%h: got valM=%h pc=%h err=%b want valM=%h pc=%h err=%b", t, ic, o.valM, o.new_pc, o.err, x.valM, x.new_pc, x.err);
            else n_pass++;
            if (x.req_cycles > 0) begin
                n_total++;
                if (!o.stable || o.we !== x.we || o.addr !== x.addr || (x.we && o.wdata !== x.wdata))
                    $display("FAIL rand%0d_req ic=%h: got we=%b addr=%h wd=%h stable=%b want we=%b addr=%h wd=%h", t, ic, o.we, o.addr, o.wdata, o.stable, x.we, x.addr, x.wdata);
                else n_pass++;
            end
            n_total++;
            if (o.done_after !== 1'b0 || !o.held) $display("FAIL rand%0d_after_done: got done=%b held=%b want 0/1", t, o.done_after, o.held);
            else n_pass++;
        end
    endtask

    initial begin
        clk = 0; rst_n = 0; start = 0; icode = 0; cnd = 0;
        valE = 0; valA = 0; valC = 0; valP = 0; mem_ack = 0; mem_rdata = 0;
        @(negedge clk);
        test_reset;
        test_mrmovq;
        test_reset_mid_access;
        test_call;
        test_ret;
        test_jxx;
        test_range_error;
        test_timeout;
        test_start_ignored;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
